dut_stim_capture: RTL and testbench
===================================

// Module: dut_stim_capture
// PURPOSE
//  Upstream/downstream harness stage for the combinational c432_enc DUT (46-bit dut_inputs, 7-bit dut_outputs).
//  Byte-loads a 46-bit vector (36 primary inputs + 10 key bits) from the host, optionally precharges the DUT
//  to all-zero, then applies the vector with a scope trigger. After a settle window it captures dut_outputs.
//  One vector per run, so power traces align to a single input transition.
// PARAMETERS
//  IN_W           46  DUT input width; NBYTES = ceil(IN_W/8) = 6
//  OUT_W          7   DUT output width
//  SETTLE_CYCLES  4   cycles trigger is high / DUT settles before capture; legal range >= 1
//  PRECHARGE      1   1: drive all-zero vector for 1 cycle before the stimulus; 0: skip
// PORTS
//  clk           in   1      single clock
//  rst           in   1      synchronous, active-high reset
//  load_valid    in   1      host byte valid
//  load_ready    out  1      byte accepted when load_valid & load_ready
//  load_data     in   8      stimulus byte, MSB-first stream
//  clear         in   1      zero staging register and byte count (IDLE only)
//  go            in   1      start a run (level sampled each cycle)
//  staged_full   out  1      NBYTES bytes loaded since reset/clear
//  busy          out  1      run in progress
//  trigger       out  1      scope trigger, high during settle window
//  go_err        out  1      1-cycle pulse: go seen in IDLE with staged_full=0
//  dut_inputs    out  IN_W   registered drive to DUT
//  dut_outputs   in   OUT_W  DUT response (combinational)
//  result        out  OUT_W  captured response, held until next capture
//  result_valid  out  1      1-cycle pulse when result updates
// BEHAVIOUR
//  Reset values: load_ready=1, staged_full=0, busy=0, trigger=0, go_err=0, result_valid=0. dut_inputs=0, result=0.
//   Internal: staging=0, byte_cnt=0, state=IDLE, settle_cnt=0. rst mid-run aborts immediately to these values.
//  Loading: in IDLE, load_ready=1. On accept, staging <= {staging[8*NBYTES-9:0], load_data}.
//   byte_cnt increments and saturates at NBYTES; staged_full = (byte_cnt==NBYTES).
//   The vector is staging[IN_W-1:0]; the top 2 bits of the first byte are discarded.
//   Further bytes keep shifting (sliding window). load_ready=0 whenever busy; no bytes accepted.
//  clear in IDLE: staging<=0, byte_cnt<=0. clear with a same-cycle byte accept: clear wins.
//   clear ignored while busy.
//  FSM: IDLE -> (PRE if PRECHARGE) -> SETTLE -> IDLE.
//   IDLE: go & staged_full -> PRE/SETTLE, busy<=1.
//     go & !staged_full -> go_err pulse, stay IDLE. go uses the pre-edge staging, even with a same-edge byte accept.
//   PRE: dut_inputs=0 for exactly 1 cycle, trigger=0 -> SETTLE.
//   SETTLE: dut_inputs=staging[IN_W-1:0], trigger=1 for exactly SETTLE_CYCLES cycles (settle_cnt counts up).
//     At the edge ending the last SETTLE cycle: result<=dut_outputs, result_valid<=1 (next cycle only), trigger<=0, busy<=0 -> IDLE.
//  Timing: go sampled at edge E0. result_valid is high in the cycle after edge E(PRECHARGE+SETTLE_CYCLES).
//   trigger rises in the cycle after E(PRECHARGE).
//  After a run, dut_inputs holds the applied vector (no glitch) until the next run's PRE/SETTLE.
//   Staging is retained, so a repeated go re-runs the same vector.
//  go while busy: ignored, no go_err. Back-to-back: go held high re-launches on the IDLE cycle following completion.
// TESTING (bench stub: dut_outputs = dut_inputs[6:0] ^ dut_inputs[45:39])
//  1. rst; load 6 bytes 0x3F,0xFF,0x00,0x00,0x00,0x81; go
//     -> staged_full=1. PRE cycle dut_inputs=0. SETTLE dut_inputs=46'h3FFF_0000_0081.
//     -> trigger high 4 cycles. result=7'h01^7'h7F=7'h7E. result_valid at E5.
//  2. PRECHARGE=0, SETTLE_CYCLES=1, same vector -> no zero cycle; trigger 1 cycle; result_valid at E1.
//  3. load 3 bytes then go -> go_err 1-cycle pulse, busy stays 0, dut_inputs unchanged.
//  4. load_valid held during run -> load_ready=0, staging unchanged. 7th byte 0xAA after run -> window shifts, low byte=0xAA.
//  5. rst asserted in 2nd SETTLE cycle -> next cycle all outputs at reset values, no result_valid.
//  6. clear with simultaneous byte accept -> byte_cnt=0, staging=0. go then pulses go_err.

Source files
------------

// File: rtl/dut_stim_capture.sv
// Stimulus staging and capture stage for a combinational DUT.
// It byte-loads one input vector, optionally precharges to zero, applies the vector under a scope trigger, then captures the response.
module dut_stim_capture #(
    parameter int IN_W          = 46,
    parameter int OUT_W         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int PRECHARGE     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [7:0]       load_data,
    input  logic             clear,
    input  logic             go,
    output logic             staged_full,
    output logic             busy,
    output logic             trigger,
    output logic             go_err,
    output logic [IN_W-1:0]  dut_inputs,
    input  logic [OUT_W-1:0] dut_outputs,
    output logic [OUT_W-1:0] result,
    output logic             result_valid
);
    localparam int NBYTES = (IN_W + 7) / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] NBYTES_C    = CNT_W'(NBYTES);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRE, SETTLE} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   staging_q, staging_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic              busy_q, busy_d;
    logic              trigger_q, trigger_d;
    logic              go_err_q, go_err_d;
    logic              result_valid_q, result_valid_d;
    logic [IN_W-1:0]   dut_inputs_q, dut_inputs_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              accept;

    assign load_ready   = (state_q == IDLE);
    assign staged_full  = (byte_cnt_q == NBYTES_C);
    assign busy         = busy_q;
    assign trigger      = trigger_q;
    assign go_err       = go_err_q;
    assign dut_inputs   = dut_inputs_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign accept       = load_valid & load_ready;

    always_comb begin
        state_d        = state_q;
        staging_d      = staging_q;
        vec_d          = vec_q;
        byte_cnt_d     = byte_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        busy_d         = busy_q;
        trigger_d      = trigger_q;
        go_err_d       = 1'b0;
        result_valid_d = 1'b0;
        dut_inputs_d   = dut_inputs_q;
        result_d       = result_q;
        unique case (state_q)
            IDLE: begin
                // Only the low IN_W bits are kept, so the top bits of the oldest byte fall off.
                if (clear) begin
                    staging_d  = '0;
                    byte_cnt_d = '0;
                end else if (accept) begin
                    staging_d  = {staging_q[IN_W-9:0], load_data};
                    byte_cnt_d = staged_full ? byte_cnt_q : byte_cnt_q + 1'b1;
                end
                if (go) begin
                    if (staged_full) begin
                        vec_d  = staging_q;
                        busy_d = 1'b1;
                        if (PRECHARGE != 0) begin
                            state_d      = PRE;
                            dut_inputs_d = '0;
                        end else begin
                            state_d      = SETTLE;
                            dut_inputs_d = staging_q;
                            trigger_d    = 1'b1;
                            settle_cnt_d = '0;
                        end
                    end else begin
                        go_err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                state_d      = SETTLE;
                dut_inputs_d = vec_q;
                trigger_d    = 1'b1;
                settle_cnt_d = '0;
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    result_d       = dut_outputs;
                    result_valid_d = 1'b1;
                    trigger_d      = 1'b0;
                    busy_d         = 1'b0;
                    state_d        = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            staging_q      <= '0;
            vec_q          <= '0;
            byte_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            busy_q         <= 1'b0;
            trigger_q      <= 1'b0;
            go_err_q       <= 1'b0;
            result_valid_q <= 1'b0;
            dut_inputs_q   <= '0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            staging_q      <= staging_d;
            vec_q          <= vec_d;
            byte_cnt_q     <= byte_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            busy_q         <= busy_d;
            trigger_q      <= trigger_d;
            go_err_q       <= go_err_d;
            result_valid_q <= result_valid_d;
            dut_inputs_q   <= dut_inputs_d;
            result_q       <= result_d;
        end
    end
endmodule

// File: tb/tb_dut_stim_capture.sv
// Directed bench for dut_stim_capture: default build plus a no-precharge, single-settle-cycle build.
module tb_dut_stim_capture;
    logic        clk = 1'b0;
    logic        rst, load_valid, clear, go0, go1;
    logic [7:0]  load_data;

    logic        load_ready0, staged_full0, busy0, trigger0, go_err0, result_valid0;
    logic [45:0] dut_inputs0;
    logic [6:0]  dut_outputs0, result0;
    logic        load_ready1, staged_full1, busy1, trigger1, go_err1, result_valid1;
    logic [45:0] dut_inputs1;
    logic [6:0]  dut_outputs1, result1;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [45:0] VEC_A = 46'h3FFF_0000_0081;
    localparam logic [45:0] VEC_B = 46'h1122_3344_5566;

    always #5 clk = ~clk;

    assign dut_outputs0 = dut_inputs0[6:0] ^ dut_inputs0[45:39];
    assign dut_outputs1 = dut_inputs1[6:0] ^ dut_inputs1[45:39];

    dut_stim_capture u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .clear(clear), .go(go0), .staged_full(staged_full0),
        .busy(busy0), .trigger(trigger0), .go_err(go_err0), .dut_inputs(dut_inputs0),
        .dut_outputs(dut_outputs0), .result(result0), .result_valid(result_valid0)
    );

    dut_stim_capture #(.PRECHARGE(0), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .clear(clear), .go(go1), .staged_full(staged_full1),
        .busy(busy1), .trigger(trigger1), .go_err(go_err1), .dut_inputs(dut_inputs1),
        .dut_outputs(dut_outputs1), .result(result1), .result_valid(result_valid1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_tests++;
        if ({load_ready0, staged_full0, busy0, trigger0, go_err0, result_valid0} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {load_ready0, staged_full0, busy0, trigger0, go_err0, result_valid0});
        end
        n_tests++;
        if (dut_inputs0 !== 46'h0 || result0 !== 7'h0) begin
            n_fail++;
            $display("FAIL reset_data got dut_inputs=%h result=%h want 0/0", dut_inputs0, result0);
        end
    endtask

    task automatic test_precharge_run();
        load_byte(8'h3F); load_byte(8'hFF); load_byte(8'h00);
        load_byte(8'h00); load_byte(8'h00); load_byte(8'h81);
        n_tests++;
        if (staged_full0 !== 1'b1) begin
            n_fail++;
            $display("FAIL staged_full got %b want 1", staged_full0);
        end
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        n_tests++;
        if (busy0 !== 1'b1 || dut_inputs0 !== 46'h0 || trigger0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_cycle got busy=%b din=%h trig=%b want 1/0/0", busy0, dut_inputs0, trigger0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (trigger0 !== 1'b1 || dut_inputs0 !== VEC_A || result_valid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL settle_%0d got trig=%b din=%h rv=%b want 1/%h/0",
                         i, trigger0, dut_inputs0, result_valid0, VEC_A);
            end
        end
        cyc();
        n_tests++;
        if (result_valid0 !== 1'b1 || result0 !== 7'h7E || trigger0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL capture got rv=%b res=%h trig=%b busy=%b want 1/7e/0/0",
                     result_valid0, result0, trigger0, busy0);
        end
        cyc();
        n_tests++;
        if (result_valid0 !== 1'b0 || dut_inputs0 !== VEC_A || result0 !== 7'h7E) begin
            n_fail++;
            $display("FAIL post_run got rv=%b din=%h res=%h want 0/%h/7e",
                     result_valid0, dut_inputs0, result0, VEC_A);
        end
    endtask

    task automatic test_no_precharge();
        go1 = 1'b1;
        cyc();
        go1 = 1'b0;
        n_tests++;
        if (trigger1 !== 1'b1 || dut_inputs1 !== VEC_A || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL np_settle got trig=%b din=%h busy=%b want 1/%h/1", trigger1, dut_inputs1, busy1, VEC_A);
        end
        cyc();
        n_tests++;
        if (result_valid1 !== 1'b1 || result1 !== 7'h7E || trigger1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL np_capture got rv=%b res=%h trig=%b busy=%b want 1/7e/0/0",
                     result_valid1, result1, trigger1, busy1);
        end
    endtask

    task automatic test_go_err();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        n_tests++;
        if (go_err0 !== 1'b1 || busy0 !== 1'b0 || dut_inputs0 !== VEC_A) begin
            n_fail++;
            $display("FAIL go_err got err=%b busy=%b din=%h want 1/0/%h", go_err0, busy0, dut_inputs0, VEC_A);
        end
        cyc();
        n_tests++;
        if (go_err0 !== 1'b0 || staged_full0 !== 1'b0) begin
            n_fail++;
            $display("FAIL go_err_pulse got err=%b full=%b want 0/0", go_err0, staged_full0);
        end
    endtask

    task automatic test_load_during_run();
        load_byte(8'h44); load_byte(8'h55); load_byte(8'h66);
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (load_ready0 !== 1'b0 || dut_inputs0 !== VEC_B) begin
                n_fail++;
                $display("FAIL busy_load_%0d got ready=%b din=%h want 0/%h", i, load_ready0, dut_inputs0, VEC_B);
            end
        end
        cyc();
        n_tests++;
        if (result_valid0 !== 1'b1 || result0 !== 7'h44 || load_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_load_capture got rv=%b res=%h ready=%b want 1/44/1",
                     result_valid0, result0, load_ready0);
        end
        cyc();
        load_valid = 1'b0;
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        cyc();
        n_tests++;
        if (dut_inputs0 !== 46'h2233_4455_66AA) begin
            n_fail++;
            $display("FAIL window_shift got din=%h want 2233445566aa", dut_inputs0);
        end
        for (int i = 0; i < 4; i++) cyc();
        n_tests++;
        if (result_valid0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL window_run_done got rv=%b busy=%b want 1/0", result_valid0, busy0);
        end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_tests++;
        if ({load_ready0, staged_full0, busy0, trigger0, go_err0, result_valid0} !== 6'b100000 ||
            dut_inputs0 !== 46'h0 || result0 !== 7'h0) begin
            n_fail++;
            $display("FAIL abort got ctrl=%b din=%h res=%h want 100000/0/0",
                     {load_ready0, staged_full0, busy0, trigger0, go_err0, result_valid0}, dut_inputs0, result0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++;
            if (result_valid0 !== 1'b0 || busy0 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet_%0d got rv=%b busy=%b want 0/0", i, result_valid0, busy0);
            end
        end
    endtask

    task automatic test_clear_vs_load();
        load_byte(8'h01); load_byte(8'h02);
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h03;
        cyc();
        clear      = 1'b0;
        load_valid = 1'b0;
        load_byte(8'h04); load_byte(8'h05); load_byte(8'h06); load_byte(8'h07); load_byte(8'h08);
        n_tests++;
        if (staged_full0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wins got full=%b want 0", staged_full0);
        end
        go0 = 1'b1;
        cyc();
        go0 = 1'b0;
        n_tests++;
        if (go_err0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_go_err got err=%b busy=%b want 1/0", go_err0, busy0);
        end
        load_byte(8'h09);
        n_tests++;
        if (staged_full0 !== 1'b1) begin
            n_fail++;
            $display("FAIL refill got full=%b want 1", staged_full0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        clear      = 1'b0;
        go0        = 1'b0;
        go1        = 1'b0;
        test_reset();
        test_precharge_run();
        test_no_precharge();
        test_go_err();
        test_load_during_run();
        test_reset_mid_run();
        test_clear_vs_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
